seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 98 +++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master drives the request; the slave (the divider) returns the results.
interface seq_divider_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, err
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, err
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, 2*WIDTH cycles per divide.
// A zero divisor short-circuits to DONE with err set and a saturated quotient.
module seq_divider #(
    parameter int WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;
    logic [QW-1:0]    r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;

    // r_quo starts as the dividend and fills with quotient bits from the LSB side,
    // so its MSB is always the next dividend bit to bring into the remainder.
    assign w_shift = {r_rem[WIDTH-1:0], r_quo[QW-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};
    assign w_neg   = w_diff[WIDTH+1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.divisor != '0) begin
                            r_div   <= bus.divisor;
                            r_quo   <= bus.dividend;
                            r_rem   <= '0;
                            r_cnt   <= CW'(QW);
                            r_err   <= 1'b0;
                            r_state <= S_CALC;
                        end else begin
                            r_quo   <= '1;
                            r_rem   <= {1'b0, bus.dividend[WIDTH-1:0]};
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_neg ? w_shift : w_diff[WIDTH:0];
                    r_quo <= {r_quo[QW-2:0], ~w_neg};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rem[WIDTH-1:0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=6 with hand-computed results,
// plus a short pseudo-random sweep checked against the division identity.
module tb_seq_divider;
    localparam int WIDTH = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Launch one divide from IDLE, wait for done, capture results, return in IDLE.
    // lat counts edges after the accepting edge until done is seen.
    task automatic do_op(input logic [11:0] a, input logic [5:0] b,
                         output logic [11:0] q, output logic [5:0] r,
                         output logic e, output int lat, output logic busy_ok);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        q = bus.quotient;
        r = bus.remainder;
        e = bus.err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [11:0] q; logic [5:0] r; logic e; int lat; logic bok;
        #12;
        checks++; if (bus.quotient !== 12'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", bus.quotient); end
        checks++; if (bus.remainder !== 6'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", bus.remainder); end
        checks++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.err}); end
        // release reset with start already high: the first edge must accept it
        @(negedge clk);
        rst_n = 1'b1;
        do_op(12'd100, 6'd7, q, r, e, lat, bok);
        checks++; if (lat != 12) begin errors++; $display("FAIL first_edge_latency got %0d want 12", lat); end
        checks++; if (q !== 12'd14) begin errors++; $display("FAIL first_edge_quotient got %0d want 14", q); end
    endtask

    task automatic test_basic();
        logic [11:0] q; logic [5:0] r; logic e; int lat; logic bok;
        do_op(12'd100, 6'd7, q, r, e, lat, bok);
        checks++; if (q !== 12'd14) begin errors++; $display("FAIL basic_quotient got %0d want 14", q); end
        checks++; if (r !== 6'd2) begin errors++; $display("FAIL basic_remainder got %0d want 2", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", e); end
        checks++; if (lat != 12) begin errors++; $display("FAIL basic_latency got %0d want 12", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bok); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_boundaries();
        logic [11:0] q; logic [5:0] r; logic e; int lat; logic bok;
        do_op(12'd4095, 6'd1, q, r, e, lat, bok);
        checks++; if (q !== 12'd4095) begin errors++; $display("FAIL max_quotient got %0d want 4095", q); end
        checks++; if (r !== 6'd0) begin errors++; $display("FAIL max_remainder got %0d want 0", r); end
        do_op(12'd5, 6'd63, q, r, e, lat, bok);
        checks++; if (q !== 12'd0) begin errors++; $display("FAIL small_quotient got %0d want 0", q); end
        checks++; if (r !== 6'd5) begin errors++; $display("FAIL small_remainder got %0d want 5", r); end
        do_op(12'd4095, 6'd63, q, r, e, lat, bok);
        checks++; if ({q, r} !== {12'd65, 6'd0}) begin errors++; $display("FAIL full_range got %0d r %0d want 65 r 0", q, r); end
    endtask

    task automatic test_div_zero();
        logic [11:0] q; logic [5:0] r; logic e; int lat; logic bok;
        do_op(12'd300, 6'd0, q, r, e, lat, bok);
        checks++; if (lat != 0) begin errors++; $display("FAIL dz_latency got %0d edges after accept want 0", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL dz_err got %b want 1", e); end
        checks++; if (q !== 12'd4095) begin errors++; $display("FAIL dz_quotient got %0d want 4095", q); end
        checks++; if (r !== 6'd44) begin errors++; $display("FAIL dz_remainder got %0d want 44", r); end
        // results must persist through IDLE
        checks++; if ({bus.quotient, bus.remainder, bus.err} !== {12'd4095, 6'd44, 1'b1}) begin
            errors++; $display("FAIL dz_hold got %0d r %0d e %b want 4095 r 44 e 1", bus.quotient, bus.remainder, bus.err);
        end
        do_op(12'd100, 6'd7, q, r, e, lat, bok);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL dz_clear_err got %b want 0", e); end
        checks++; if ({q, r} !== {12'd14, 6'd2}) begin errors++; $display("FAIL dz_follow got %0d r %0d want 14 r 2", q, r); end
    endtask

    task automatic test_ignored_start();
        logic bok = 1'b1;
        logic early = 1'b0;
        bus.dividend = 12'd100;
        bus.divisor  = 6'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c == 3 || c == 13) begin
                bus.start    = 1'b1;
                bus.dividend = 12'd200;
                bus.divisor  = 6'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (c <= 12 && bus.busy !== 1'b1) bok = 1'b0;
            if (c < 12 && bus.done === 1'b1) early = 1'b1;
            if (c == 12) begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", bus.done); end
            end
        end
        bus.start = 1'b0;
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", bok); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL ign_early_done got %b want 0", early); end
        checks++; if ({bus.quotient, bus.remainder} !== {12'd14, 6'd2}) begin
            errors++; $display("FAIL ign_result got %0d r %0d want 14 r 2", bus.quotient, bus.remainder);
        end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_relaunch got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_calc();
        logic [11:0] q; logic [5:0] r; logic e; int lat; logic bok;
        logic saw_done = 1'b0;
        bus.dividend = 12'd100;
        bus.divisor  = 6'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.err} !== 21'd0) begin
            errors++; $display("FAIL abort_outputs got %0d r %0d flags %b want all 0", bus.quotient, bus.remainder, {bus.busy, bus.done, bus.err});
        end
        repeat (3) begin @(posedge clk); #1; if (bus.done !== 1'b0) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", saw_done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(12'd100, 6'd7, q, r, e, lat, bok);
        checks++; if ({q, r, e} !== {12'd14, 6'd2, 1'b0}) begin errors++; $display("FAIL abort_recover got %0d r %0d e %b want 14 r 2 e 0", q, r, e); end
        checks++; if (lat != 12) begin errors++; $display("FAIL abort_latency got %0d want 12", lat); end
    endtask

    task automatic test_held_start();
        int n;
        bus.dividend = 12'd100;
        bus.divisor  = 6'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.dividend = 12'd50;
        bus.divisor  = 6'd6;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if ({bus.quotient, bus.remainder} !== {12'd14, 6'd2} || n != 12) begin
            errors++; $display("FAIL held_first got %0d r %0d after %0d want 14 r 2 after 12", bus.quotient, bus.remainder, n);
        end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_idle got %b want 0", bus.busy); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL held_relaunch got %b want 1", bus.busy); end
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if ({bus.quotient, bus.remainder} !== {12'd8, 6'd2} || n != 12) begin
            errors++; $display("FAIL held_second got %0d r %0d after %0d want 8 r 2 after 12", bus.quotient, bus.remainder, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [11:0] q; logic [5:0] r; logic e; int lat; logic bok;
        logic [11:0] a; logic [5:0] b;
        int exp_q, exp_r;
        for (int i = 0; i < 300; i++) begin
            a = 12'($urandom_range(0, 4095));
            b = 6'($urandom_range(1, 63));
            exp_q = int'(a) / int'(b);
            exp_r = int'(a) % int'(b);
            do_op(a, b, q, r, e, lat, bok);
            checks++; if (int'(q) != exp_q || int'(r) != exp_r) begin
                errors++; $display("FAIL rand_result %0d/%0d got %0d r %0d want %0d r %0d", a, b, q, r, exp_q, exp_r);
            end
            checks++; if (int'(q) * int'(b) + int'(r) != int'(a) || r >= b) begin
                errors++; $display("FAIL rand_identity %0d/%0d got %0d r %0d", a, b, q, r);
            end
            checks++; if (lat != 12 || e !== 1'b0) begin
                errors++; $display("FAIL rand_timing %0d/%0d got lat %0d err %b want 12 0", a, b, lat, e);
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignored_start();
        test_reset_mid_calc();
        test_held_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
